msrv32_instruction_mux_core: RTL and testbench
==============================================

// Module: msrv32_instruction_mux_core
// PURPOSE
//  Fetch-to-decode instruction mux of the MSRV32 pipeline. Forwards the fetched 32-bit instruction
//  or, when the pipeline is flushed, a canonical NOP (ADDI x0,x0,0 = 32'h0000_0013).
//  Splits the selected word into RV32I fields for the decoder, register file and CSR file.
//  Flags encodings that are not 32-bit RV32I base opcodes.
// PARAMETERS
//  NOP_INSTR  32'h0000_0013  word substituted while flush_in=1
// PORTS
//  ms_riscv32_mp_clk_in    in   1   single clock, rising edge
//  ms_riscv32_mp_rst_n_in  in   1   asynchronous reset, active-low
//  flush_in                in   1   1 = substitute NOP_INSTR for the fetched word
//  ms_riscv32_mp_instr_in  in   32  fetched instruction
//  opcode_out              out  7   sel[6:0]
//  funct3_out              out  3   sel[14:12]
//  funct7_out              out  7   sel[31:25]
//  rs1addr_out             out  5   sel[19:15]
//  rs2addr_out             out  5   sel[24:20]
//  rdaddr_out              out  5   sel[11:7]
//  csr_addr_out            out  12  sel[31:20]
//  instr_out               out  25  sel[31:7], used for immediate generation
//  illegal_instr_out       out  1   sel is not a legal RV32I base opcode
// BEHAVIOUR
//  - sel = flush_in ? NOP_INSTR : ms_riscv32_mp_instr_in.
//    All field outputs are pure bit slices of sel. No arithmetic and no sign extension.
//  - illegal_instr_out = 1 when sel[1:0] != 2'b11, or when sel[6:0] is not one of:
//    37,17,6F,67,63,03,23,13,33,0F,73 (hex).
//  - During flush, sel=NOP_INSTR. NOP_INSTR is legal, so illegal_instr_out=0.
//  - Default build:
//    - All outputs are combinational from flush_in and ms_riscv32_mp_instr_in, with zero latency.
//    - Clock and reset are ignored, and the block holds no state.
//    - Any input change is visible on the outputs in the same delta cycle.
//  - Glitch-free selection is not required; consumers sample the outputs on the clock edge.
//  - The CSR field overlaps the funct7 and rs2 fields. The outputs must stay consistent:
//    csr_addr_out == {funct7_out, rs2addr_out}.
// CONFIGURATION
//  - Macro MSRV32_INSTR_MUX_REG_OUT_EN.
//  - Defined: sel and all derived outputs come from a single 32-bit register.
//    - On each rising clock edge the register captures sel. Latency is 1 clock.
//    - flush_in is also sampled on the clock edge. A flush asserted in cycle N yields NOP
//      fields in cycle N+1.
//    - Asserting ms_riscv32_mp_rst_n_in=0 immediately (asynchronously) forces the register to
//      NOP_INSTR:
//      - opcode_out=7'h13, all other fields 0, illegal_instr_out=0.
//    - The register holds that value until the first rising edge after reset release.
//    - Reset asserted mid-stream discards the in-flight word.
//  - Undefined: the combinational default build described above.
// TESTING
//  - flush=0, instr=32'h0000_0013:
//    opcode=13, funct3=0, funct7=00, rs1=rs2=rd=00, csr=000, instr_out=0000000, illegal=0.
//  - flush=1, instr=32'h1234_5678:
//    NOP fields (opcode=13, funct3=0, funct7=00, rs1=rs2=rd=00, csr=000, instr_out=0000000),
//    illegal=0.
//  - flush=0, instr=32'h8765_4321:
//    opcode=21, funct3=4, funct7=43, rs1=0A, rs2=16, rd=06, csr=876, instr_out=10ECA86,
//    illegal=1.
//  - flush=0, instr=32'h3420_2573 (csrrs a0,mstatus? no, mepc read):
//    opcode=73, funct3=2, rd=0A, rs1=00, csr=342, illegal=0.
//  - flush=0, legal-width unknown opcode 32'h0000_007F -> illegal=1.
//    Any word with bits[1:0]=00 -> illegal=1.
//  - Registered build:
//    - Drive rst_n=0 mid-stream -> outputs show NOP fields immediately.
//    - Release rst_n; the word applied before the next edge appears one clock later.
//    - A flush pulse affects exactly one output cycle.

Source files
------------

// File: rtl/msrv32_instruction_mux_core.sv
// Fetch-to-decode instruction mux: forwards the fetched word or a NOP on flush, splits RV32I fields.
// Optional output register enabled by defining MSRV32_INSTR_MUX_REG_OUT_EN (default: combinational).
module msrv32_instruction_mux_core #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        flush_in,
    input  logic [31:0] ms_riscv32_mp_instr_in,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic [6:0]  funct7_out,
    output logic [4:0]  rs1addr_out,
    output logic [4:0]  rs2addr_out,
    output logic [4:0]  rdaddr_out,
    output logic [11:0] csr_addr_out,
    output logic [24:0] instr_out,
    output logic        illegal_instr_out
);

    // Only the eleven 32-bit RV32I base opcodes are accepted; every one of them ends in 2'b11.
    function automatic logic is_illegal(input logic [31:0] word);
        logic bad;
        if (word[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (word[6:0])
                7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: bad = 1'b0;
                default:                           bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    logic [31:0] sel_s;
    logic [31:0] word_s;

    // Select between the fetched word and the canonical NOP.
    always_comb begin
        if (flush_in) begin
            sel_s = NOP_INSTR;
        end else begin
            sel_s = ms_riscv32_mp_instr_in;
        end
    end

`ifdef MSRV32_INSTR_MUX_REG_OUT_EN
    logic [31:0] word_r;

    // Single pipeline register; reset loads a NOP so the decoder never sees garbage.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            word_r <= NOP_INSTR;
        end else begin
            word_r <= sel_s;
        end
    end

    assign word_s = word_r;
`else
    logic unused_clk_rst_s;

    assign unused_clk_rst_s = ms_riscv32_mp_clk_in ^ ms_riscv32_mp_rst_n_in;
    assign word_s           = sel_s;
`endif

    // Every field is a plain slice of one word, so csr_addr stays equal to {funct7, rs2}.
    assign opcode_out        = word_s[6:0];
    assign rdaddr_out        = word_s[11:7];
    assign funct3_out        = word_s[14:12];
    assign rs1addr_out       = word_s[19:15];
    assign rs2addr_out       = word_s[24:20];
    assign funct7_out        = word_s[31:25];
    assign csr_addr_out      = word_s[31:20];
    assign instr_out         = word_s[31:7];
    assign illegal_instr_out = is_illegal(word_s);

endmodule

// File: tb/tb_msrv32_instruction_mux_core.sv
// Self-checking bench for msrv32_instruction_mux_core; follows MSRV32_INSTR_MUX_REG_OUT_EN if defined.
module tb_msrv32_instruction_mux_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = 32'h0000_0000;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rs1addr_out;
    logic [4:0]  rs2addr_out;
    logic [4:0]  rdaddr_out;
    logic [11:0] csr_addr_out;
    logic [24:0] instr_out;
    logic        illegal_instr_out;

    int tests = 0;
    int fails = 0;

    logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    msrv32_instruction_mux_core dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_n_in(rst_n),
        .flush_in              (flush),
        .ms_riscv32_mp_instr_in(instr),
        .opcode_out            (opcode_out),
        .funct3_out            (funct3_out),
        .funct7_out            (funct7_out),
        .rs1addr_out           (rs1addr_out),
        .rs2addr_out           (rs2addr_out),
        .rdaddr_out            (rdaddr_out),
        .csr_addr_out          (csr_addr_out),
        .instr_out             (instr_out),
        .illegal_instr_out     (illegal_instr_out)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] observed();
        return {opcode_out, funct3_out, funct7_out, rs1addr_out, rs2addr_out,
                rdaddr_out, csr_addr_out, instr_out, illegal_instr_out};
    endfunction

    // Reference: fields by integer division/modulo, legality by table lookup.
    function automatic logic [69:0] model(input logic [31:0] w_in, input logic fl);
        longint unsigned w;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  r1, r2, rd;
        logic [11:0] csr;
        logic [24:0] imm;
        logic        legal;
        w   = fl ? 64'h13 : {32'h0, w_in};
        op  = 7'(w % 128);
        rd  = 5'((w / 128) % 32);
        f3  = 3'((w / 4096) % 8);
        r1  = 5'((w / 32768) % 32);
        r2  = 5'((w / 1048576) % 32);
        f7  = 7'(w / 33554432);
        csr = 12'(w / 1048576);
        imm = 25'(w / 128);
        legal = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (op == legal_ops[i]) legal = 1'b1;
        end
        if ((w % 4) != 3) legal = 1'b0;
        return {op, f3, f7, r1, r2, rd, csr, imm, ~legal};
    endfunction

    // Apply one word; afterwards the outputs reflect it (one clock later if registered).
    task automatic drive(input logic [31:0] w, input logic fl);
`ifdef MSRV32_INSTR_MUX_REG_OUT_EN
        @(negedge clk);
        instr = w;
        flush = fl;
        @(posedge clk);
        #1;
`else
        instr = w;
        flush = fl;
        #1;
`endif
    endtask

    task automatic test_reset();
        logic [69:0] exp;
        rst_n = 1'b0;
        instr = 32'h8765_4321;
        flush = 1'b0;
        #1;
`ifdef MSRV32_INSTR_MUX_REG_OUT_EN
        exp = model(32'h0000_0013, 1'b0);
`else
        exp = model(32'h8765_4321, 1'b0);
`endif
        tests++;
        if (observed() !== exp) begin
            $display("FAIL reset_state got=%h exp=%h", observed(), exp);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] words [5] = '{32'h0000_0013, 32'h1234_5678, 32'h8765_4321,
                                   32'h3420_2573, 32'h0000_007F};
        logic        fls   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [69:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(words[i], fls[i]);
            exp = model(words[i], fls[i]);
            tests++;
            if (observed() !== exp) begin
                $display("FAIL directed_%0d got=%h exp=%h", i, observed(), exp);
                fails++;
            end
        end
        drive(32'h8765_4321, 1'b0);
        tests++;
        if ({funct7_out, rs1addr_out, csr_addr_out, instr_out, illegal_instr_out}
                !== {7'h43, 5'h0A, 12'h876, 25'h10ECA86, 1'b1}) begin
            $display("FAIL spec_8765_4321 got=%h/%h/%h/%h/%b", funct7_out, rs1addr_out,
                     csr_addr_out, instr_out, illegal_instr_out);
            fails++;
        end
        drive(32'h3420_2573, 1'b0);
        tests++;
        if ({opcode_out, funct3_out, rdaddr_out, rs1addr_out, csr_addr_out, illegal_instr_out}
                !== {7'h73, 3'h2, 5'h0A, 5'h00, 12'h342, 1'b0}) begin
            $display("FAIL spec_csr_read got=%h/%h/%h/%h/%h/%b", opcode_out, funct3_out,
                     rdaddr_out, rs1addr_out, csr_addr_out, illegal_instr_out);
            fails++;
        end
    endtask

    task automatic test_low_bits();
        logic [31:0] w;
        for (int i = 0; i < 11; i++) begin
            w = $urandom();
            w[6:0] = legal_ops[i] & 7'h7C;
            drive(w, 1'b0);
            tests++;
            if (illegal_instr_out !== 1'b1) begin
                $display("FAIL low_bits_00 word=%h got=%b exp=1", w, illegal_instr_out);
                fails++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        fl;
        logic [69:0] exp;
        for (int i = 0; i < 300; i++) begin
            w  = $urandom();
            fl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) w[6:0] = legal_ops[$urandom_range(0, 10)];
            drive(w, fl);
            exp = model(w, fl);
            tests++;
            if (observed() !== exp) begin
                $display("FAIL random_%0d word=%h flush=%b got=%h exp=%h", i, w, fl, observed(), exp);
                fails++;
            end
            tests++;
            if (csr_addr_out !== {funct7_out, rs2addr_out}) begin
                $display("FAIL csr_overlap got=%h exp=%h", csr_addr_out, {funct7_out, rs2addr_out});
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4] = '{32'hFEDC_BA63, 32'h0123_4533, 32'hAAAA_AAAB, 32'h5555_5503};
        logic        fls   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [69:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(words[i], fls[i]);
            exp = model(words[i], fls[i]);
            tests++;
            if (observed() !== exp) begin
                $display("FAIL flush_pulse_%0d got=%h exp=%h", i, observed(), exp);
                fails++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [69:0] exp;
        drive(32'h0040_0093, 1'b0);
        @(negedge clk);
        instr = 32'hDEAD_BEE3;
        #2;
        rst_n = 1'b0;
        #1;
`ifdef MSRV32_INSTR_MUX_REG_OUT_EN
        exp = model(32'h0000_0013, 1'b0);
`else
        exp = model(32'hDEAD_BEE3, 1'b0);
`endif
        tests++;
        if (observed() !== exp) begin
            $display("FAIL mid_reset got=%h exp=%h", observed(), exp);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (observed() !== exp) begin
            $display("FAIL reset_hold got=%h exp=%h", observed(), exp);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        instr = 32'h00A5_0513;
        @(posedge clk);
        #1;
        exp = model(32'h00A5_0513, 1'b0);
        tests++;
        if (observed() !== exp) begin
            $display("FAIL after_release got=%h exp=%h", observed(), exp);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_low_bits();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
